byte_serial_adder: RTL
======================

# byte_serial_adder

Multi-byte adder that computes `out_sum = in_a + in_b + in_cin` over `NBYTES` bytes, one byte per clock, on a single `adder_8` ripple-carry slice. A carry register links successive bytes. It sits directly upstream of result consumers and downstream of operand producers, and trades latency for area wherever operands are wider than 8 bits. Operands enter and results leave through valid/ready handshakes.

## Interface
- `NBYTES`, default 4: operand width in bytes (≥1); operand width is `8*NBYTES`.
- `clk` input 1: sole clock, rising-edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: operand pair offered.
- `in_ready` output 1: block can accept operands.
- `in_a` input `8*NBYTES`: addend A.
- `in_b` input `8*NBYTES`: addend B.
- `in_cin` input 1: carry-in.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `out_sum` output `8*NBYTES`: sum, registered.
- `out_cout` output 1: carry-out of the MSB byte, registered.
- `busy` output 1: operation in progress (state RUN or DONE).
- `out_ovf` output 1: signed overflow; present only with `BYTE_SERIAL_ADDER_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `in_a` and `in_b` into shift registers, load the carry register with `in_cin`, clear the byte counter, and go to RUN.
- RUN:
  - Each cycle, `adder_8` adds the low bytes of the A and B shift registers plus the carry register.
  - The sum byte shifts into the top of the sum register (right shift).
  - The carry register takes the `adder_8` carry-out.
  - A and B shift right by 8.
  - The counter increments.
  - After byte `NBYTES-1`, go to DONE.
- DONE:
  - `out_valid`=1, with `out_sum` and `out_cout` stable.
  - On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. `in_valid` and operand changes in RUN/DONE are ignored.
- Arithmetic is unsigned modulo `2^(8*NBYTES)`. `out_cout` is the carry out of the final byte.
- `NBYTES`=1 is legal: RUN lasts one cycle.
- Byte counter width is `max(1, $clog2(NBYTES))`.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `out_sum`=0, `out_cout`=0, `out_ovf`=0.
  - Carry, counter and shift registers cleared.
- Reset during RUN or DONE abandons the operation. No result is ever emitted for it.
- Latency: accept at edge k; `out_valid` rises after edge k+`NBYTES`.
- Minimum issue interval is `NBYTES`+2 cycles: accept, `NBYTES` RUN cycles, at least one DONE cycle, then IDLE.
- `out_valid` stays high until the edge where `out_ready` is sampled high. IDLE and `in_ready`=1 follow on the next cycle.
- Back-to-back accept in the same cycle as result hand-off is not supported.

## Configuration
- `BYTE_SERIAL_ADDER_OVF_EN` defined:
  - `out_ovf` port exists, registered in the DONE transition.
  - `out_ovf` = (`a[msb]`==`b[msb]`) && (`sum[msb]`!=`a[msb]`), using the latched operand MSBs.
  - It is valid with `out_valid`; cleared by reset.
- Undefined: no `out_ovf` port and no MSB holding registers.

## Structure
- Package `byte_serial_adder_pkg`:
  - `state_t` enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constant `BYTE_W`=8.
- Sub-module: a single instance of `adder_8` (ports `sum`, `cout`, `in1`, `in2`, `cin`) as the byte datapath. No other arithmetic in the block.

## Test plan
All scenarios use `NBYTES`=4.
1. Reset, then offer a=0, b=0, cin=0 → accepted; `out_valid` 4 cycles later; sum=0x00000000, cout=0.
2. a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, with the carry propagated through all four bytes.
3. a=0x12345678, b=0x9ABCDEF0, cin=1 → sum=0xACF13569, cout=0.
4. Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `out_valid` and sum held; `in_ready`=0; `in_valid` pulses ignored. Raise `out_ready` → exactly one transfer, then `in_ready`=1 on the next cycle.
5. Assert `rst` two cycles into RUN → `out_valid`=0 and `in_ready`=1 immediately, with no stale result. Then a=0xAAAAAAAA, b=0x55555555, cin=1 → sum=0x00000000, cout=1.
6. With `BYTE_SERIAL_ADDER_OVF_EN` defined:
   - 0x7FFFFFFF+0x00000001 → ovf=1, cout=0.
   - 0x80000000+0x80000000 → sum=0, cout=1, ovf=1.
   - 0x00000001+0xFFFFFFFF → ovf=0.

Source files
------------

// File: rtl/byte_serial_adder_pkg.sv
// Shared types and constants for the byte-serial adder.
package byte_serial_adder_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_serial_adder_if.sv
// Operand/result valid-ready bundle for byte_serial_adder.
interface byte_serial_adder_if #(
    parameter int unsigned NBYTES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   in_a;
    logic [8*NBYTES-1:0]   in_b;
    logic                  in_cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   out_sum;
    logic                  out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/adder_8.sv
// 8-bit ripple-carry adder slice; the only arithmetic datapath of the serial adder.
module adder_8 (
    output logic [7:0] sum,
    output logic       cout,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       cin
);
    logic w_c;

    always_comb begin
        w_c = cin;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = in1[i] ^ in2[i] ^ w_c;
            w_c    = (in1[i] & in2[i]) | (w_c & (in1[i] ^ in2[i]));
        end
        cout = w_c;
    end
endmodule

// File: rtl/byte_serial_adder.sv
// Multi-byte adder processing one byte per clock through a single adder_8 slice.
// Optional signed-overflow output enabled by defining BYTE_SERIAL_ADDER_OVF_EN.
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    byte_serial_adder_if.slave  bus,
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    output logic                out_ovf,
`endif
    output logic                busy
);
    localparam int unsigned W  = BYTE_W * NBYTES;
    localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic            w_last;
    logic [7:0]      w_byte;
    logic            w_cout;
    logic [W+7:0]    w_sum_cat;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    logic            r_a_msb;
    logic            r_b_msb;
    logic            r_ovf;
`endif

    adder_8 u_adder_8 (
        .sum  (w_byte),
        .cout (w_cout),
        .in1  (r_a[7:0]),
        .in2  (r_b[7:0]),
        .cin  (r_carry)
    );

    assign w_last    = (r_cnt == CW'(NBYTES - 1));
    // New byte enters at the top; the concatenation also covers NBYTES == 1.
    assign w_sum_cat = {w_byte, r_sum};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid) w_state_next = RUN;
            RUN:     if (w_last)       w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        busy          = (r_state == RUN) || (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b;
                        r_carry <= bus.in_cin;
                        r_cnt   <= '0;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
                        r_a_msb <= bus.in_a[W-1];
                        r_b_msb <= bus.in_b[W-1];
`endif
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_cat[W+7:8];
                    r_carry <= w_cout;
                    r_a     <= r_a >> BYTE_W;
                    r_b     <= r_b >> BYTE_W;
                    r_cnt   <= r_cnt + CW'(1);
`ifdef BYTE_SERIAL_ADDER_OVF_EN
                    // w_byte[7] is the result MSB on the final byte.
                    if (w_last) begin
                        r_ovf <= (r_a_msb == r_b_msb) && (w_byte[7] != r_a_msb);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.out_sum  = r_sum;
    assign bus.out_cout = r_carry;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    assign out_ovf = r_ovf;
`endif
endmodule
